imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader for the MIPS core's instruction memory.
- Accepts a stream of instruction words over a valid/ready handshake and writes them into consecutive imem word addresses from 0.
- Holds the processor in reset with fetch disabled during the load, then releases it.
- Monitors the fetched PC and declares completion once the PC leaves the loaded program range.

Parameters:
IWIDTH, 32, instruction word width
PC_WIDTH, 32, processor PC width (byte address)
DEPTH, 6, imem address width in words (2^DEPTH words)

Ports:
l_clk  input  1  clock
l_rst  input  1  synchronous reset, active-high
l_i_start  input  1  begin a load session (sampled in IDLE/DONE only)
l_i_len  input  DEPTH+1  number of words to load, valid range 1..2^DEPTH, sampled with l_i_start
l_i_valid  input  1  stream word valid
l_i_data  input  IWIDTH  stream instruction word
l_o_ready  output  1  loader accepts a word this cycle
l_o_we  output  1  imem write enable
l_o_waddr  output  DEPTH  imem word address
l_o_wdata  output  IWIDTH  imem write data
l_o_cpu_hold  output  1  1 = processor held in reset (top level adapts polarity)
l_o_cpu_ce  output  1  processor chip enable
l_i_pc  input  PC_WIDTH  processor current PC
l_o_busy  output  1  state is LOAD, SETTLE or RUN
l_o_done  output  1  state is DONE
l_o_err  output  1  one-cycle pulse on rejected start
l_o_count  output  DEPTH+1  words accepted in the current session

Behaviour:
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- Reset (sync, l_rst=1 at edge) from any state, including mid-LOAD or mid-RUN:
  - state=IDLE, count=0, len register=0.
  - l_o_we=0, l_o_waddr=0, l_o_wdata=0, l_o_cpu_hold=1, l_o_cpu_ce=0, l_o_done=0, l_o_err=0, l_o_busy=0.
  - A partial load is abandoned; no further writes occur.
- IDLE/DONE:
  - l_i_start with 1<=l_i_len<=2^DEPTH: latch len, clear count, go to LOAD next cycle.
  - l_i_start with l_i_len=0 or l_i_len>2^DEPTH: stay in current state, l_o_err=1 for one cycle.
- LOAD:
  - l_o_ready=1 (combinational from state).
  - Handshake is l_i_valid & l_o_ready.
  - On handshake: registered write, i.e. next cycle l_o_we=1, l_o_waddr=count[DEPTH-1:0], l_o_wdata=word; count increments. l_o_we=0 on cycles with no handshake.
  - When the handshake takes count to len: go to SETTLE. l_o_ready=0 from the next cycle. Data held on l_i_data is ignored and not accepted.
- SETTLE (exactly 1 cycle): last write issued, hold=1, ce=0. Then RUN.
- RUN: hold=0, ce=1 from the first RUN cycle.
  - If l_i_pc >= 4*len (unsigned, PC_WIDTH compare) → DONE.
  - l_i_start is ignored.
- DONE: ce=0, hold=0 (processor state stays observable), l_o_done=1.
- l_o_cpu_hold=1 in IDLE, LOAD, SETTLE; l_o_cpu_ce=1 only in RUN.
- Address wrap: waddr uses count mod 2^DEPTH. Because len<=2^DEPTH is enforced, a valid session never writes the same address twice.
- l_i_valid in any non-LOAD state: ignored, no writes.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds input l_i_csum (IWIDTH), sampled with l_i_start.
  - A running 32-bit wrap-around sum of accepted words is kept, cleared on start.
  - In SETTLE: sum==csum → RUN; mismatch → DONE with l_o_err pulsed 1 cycle and ce never asserted.
- Undefined: no l_i_csum port; SETTLE always goes to RUN.

Test Plan:
- Reset mid-LOAD: start len=5, accept 2 words, assert l_rst → next cycle state IDLE, hold=1, ce=0, we=0, count=0; no further writes even with valid held high.
- Basic load: start len=3, stream 0x20080005, 0x20090003, 0x01095020 with valid constant → writes at addr 0,1,2 one cycle after each accept; ready drops after the 3rd; 1 SETTLE cycle; ce=1 in the following cycle.
- Backpressure gaps: len=4 with valid toggling 1,0,1,0,... → exactly 4 writes at addrs 0..3 with correct data; count=4 at SETTLE.
- Run completion: len=3; drive l_i_pc 0,4,8 → stays RUN; l_i_pc=12 → DONE next cycle, ce=0, done=1.
- Boundaries:
  - len=0 → err pulse, stays IDLE.
  - len=65 with DEPTH=6 → err.
  - len=64 → last write addr 63; start during RUN ignored.
  - Start in DONE reloads.
- With LOADER_CHECKSUM_EN: words 1,2,3 with csum=6 → RUN; csum=7 → DONE with err pulse, ce stays 0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams words into imem from address 0, holds the CPU during load, then runs it until the PC leaves the program.
// Optional checksum gate on the loaded image: define LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 6
) (
    input  logic                l_clk,
    input  logic                l_rst,
    input  logic                l_i_start,
    input  logic [DEPTH:0]      l_i_len,
`ifdef LOADER_CHECKSUM_EN
    input  logic [IWIDTH-1:0]   l_i_csum,
`endif
    input  logic                l_i_valid,
    input  logic [IWIDTH-1:0]   l_i_data,
    output logic                l_o_ready,
    output logic                l_o_we,
    output logic [DEPTH-1:0]    l_o_waddr,
    output logic [IWIDTH-1:0]   l_o_wdata,
    output logic                l_o_cpu_hold,
    output logic                l_o_cpu_ce,
    input  logic [PC_WIDTH-1:0] l_i_pc,
    output logic                l_o_busy,
    output logic                l_o_done,
    output logic                l_o_err,
    output logic [DEPTH:0]      l_o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic hold;
        logic ce;
        logic busy;
        logic done;
    } flags_t;

    localparam logic [DEPTH:0] MAX_LEN = {1'b1, {DEPTH{1'b0}}};

    state_t               state;
    flags_t               flags_q;
    logic [DEPTH:0]       len_q;
    logic [DEPTH:0]       count_q;
    logic [DEPTH:0]       count_inc;
    logic                 start_ok;
    logic                 handshake;
    logic [PC_WIDTH-1:0]  pc_limit;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]          sum_q;
    logic [IWIDTH-1:0]    csum_q;
`endif

    // Status outputs are registered alongside the state they describe.
    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f = '{hold: 1'b1, ce: 1'b0, busy: 1'b0, done: 1'b0};
        case (s)
            S_LOAD, S_SETTLE: f.busy = 1'b1;
            S_RUN:            f = '{hold: 1'b0, ce: 1'b1, busy: 1'b1, done: 1'b0};
            S_DONE:           f = '{hold: 1'b0, ce: 1'b0, busy: 1'b0, done: 1'b1};
            default:          f = '{hold: 1'b1, ce: 1'b0, busy: 1'b0, done: 1'b0};
        endcase
        return f;
    endfunction

    assign l_o_ready    = (state == S_LOAD);
    assign handshake    = l_i_valid & l_o_ready;
    assign start_ok     = (l_i_len != '0) && (l_i_len <= MAX_LEN);
    assign count_inc    = count_q + 1'b1;
    assign pc_limit     = PC_WIDTH'(len_q) << 2;
    assign l_o_cpu_hold = flags_q.hold;
    assign l_o_cpu_ce   = flags_q.ce;
    assign l_o_busy     = flags_q.busy;
    assign l_o_done     = flags_q.done;
    assign l_o_count    = count_q;

    // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge l_clk) begin
        if (l_rst) begin
            state     <= S_IDLE;
            flags_q   <= flags_of(S_IDLE);
            len_q     <= '0;
            count_q   <= '0;
            l_o_we    <= 1'b0;
            l_o_waddr <= '0;
            l_o_wdata <= '0;
            l_o_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
            csum_q    <= '0;
`endif
        end else begin
            l_o_we  <= 1'b0;
            l_o_err <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (l_i_start) begin
                        if (start_ok) begin
                            state   <= S_LOAD;
                            flags_q <= flags_of(S_LOAD);
                            len_q   <= l_i_len;
                            count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                            sum_q   <= '0;
                            csum_q  <= l_i_csum;
`endif
                        end else begin
                            l_o_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        l_o_we    <= 1'b1;
                        l_o_waddr <= count_q[DEPTH-1:0];
                        l_o_wdata <= l_i_data;
                        count_q   <= count_inc;
`ifdef LOADER_CHECKSUM_EN
                        sum_q     <= sum_q + 32'(l_i_data);
`endif
                        if (count_inc == len_q) begin
                            state   <= S_SETTLE;
                            flags_q <= flags_of(S_SETTLE);
                        end
                    end
                end
                S_SETTLE: begin
`ifdef LOADER_CHECKSUM_EN
                    // A corrupt image never gets to execute.
                    if (sum_q == 32'(csum_q)) begin
                        state   <= S_RUN;
                        flags_q <= flags_of(S_RUN);
                    end else begin
                        state   <= S_DONE;
                        flags_q <= flags_of(S_DONE);
                        l_o_err <= 1'b1;
                    end
`else
                    state   <= S_RUN;
                    flags_q <= flags_of(S_RUN);
`endif
                end
                S_RUN: begin
                    if (l_i_pc >= pc_limit) begin
                        state   <= S_DONE;
                        flags_q <= flags_of(S_DONE);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    flags_q <= flags_of(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-acceptance vector table plus directed load/run/reset sequences.
module tb_imem_loader;

    localparam int IW = 32;
    localparam int PW = 32;
    localparam int D  = 6;

    logic          l_clk;
    logic          l_rst;
    logic          l_i_start;
    logic [D:0]    l_i_len;
    logic [IW-1:0] l_i_csum;
    logic          l_i_valid;
    logic [IW-1:0] l_i_data;
    logic          l_o_ready;
    logic          l_o_we;
    logic [D-1:0]  l_o_waddr;
    logic [IW-1:0] l_o_wdata;
    logic          l_o_cpu_hold;
    logic          l_o_cpu_ce;
    logic [PW-1:0] l_i_pc;
    logic          l_o_busy;
    logic          l_o_done;
    logic          l_o_err;
    logic [D:0]    l_o_count;

    imem_loader #(.IWIDTH(IW), .PC_WIDTH(PW), .DEPTH(D)) dut (
        .l_clk        (l_clk),
        .l_rst        (l_rst),
        .l_i_start    (l_i_start),
        .l_i_len      (l_i_len),
`ifdef LOADER_CHECKSUM_EN
        .l_i_csum     (l_i_csum),
`endif
        .l_i_valid    (l_i_valid),
        .l_i_data     (l_i_data),
        .l_o_ready    (l_o_ready),
        .l_o_we       (l_o_we),
        .l_o_waddr    (l_o_waddr),
        .l_o_wdata    (l_o_wdata),
        .l_o_cpu_hold (l_o_cpu_hold),
        .l_o_cpu_ce   (l_o_cpu_ce),
        .l_i_pc       (l_i_pc),
        .l_o_busy     (l_o_busy),
        .l_o_done     (l_o_done),
        .l_o_err      (l_o_err),
        .l_o_count    (l_o_count)
    );

    initial l_clk = 1'b0;
    always #5 l_clk = ~l_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Write monitor: captures every imem write on the falling edge.
    logic [D-1:0]  mon_addr [128];
    logic [IW-1:0] mon_data [128];
    int            wr_cnt = 0;

    always @(negedge l_clk) begin
        if (l_o_we === 1'b1) begin
            if (wr_cnt < 128) begin
                mon_addr[wr_cnt] = l_o_waddr;
                mon_data[wr_cnt] = l_o_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    typedef struct {
        logic [D:0] len;
        logic       exp_err;
        logic       exp_busy;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge l_clk);
        #1;
    endtask

    task automatic do_reset();
        l_rst     = 1'b1;
        l_i_start = 1'b0;
        l_i_len   = '0;
        l_i_valid = 1'b0;
        l_i_data  = '0;
        l_i_pc    = '0;
        tick();
        tick();
        l_rst = 1'b0;
    endtask

    task automatic start_load(input logic [D:0] len);
        l_i_start = 1'b1;
        l_i_len   = len;
        tick();
        l_i_start = 1'b0;
    endtask

    task automatic stream3(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [IW-1:0] c);
        l_i_valid = 1'b1;
        l_i_data  = a;
        tick();
        l_i_data  = b;
        tick();
        l_i_data  = c;
        tick();
        l_i_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IW-1:0] w [3];
        logic [IW-1:0] bp [4];
        int base;
        int k;

        w[0] = 32'h2008_0005; w[1] = 32'h2009_0003; w[2] = 32'h0109_5020;
        bp[0] = 32'h1111_0000; bp[1] = 32'h2222_0001; bp[2] = 32'h3333_0002; bp[3] = 32'h4444_0003;

        vecs[0] = '{len: 7'd0,   exp_err: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
        vecs[1] = '{len: 7'd65,  exp_err: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
        vecs[2] = '{len: 7'd127, exp_err: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
        vecs[3] = '{len: 7'd1,   exp_err: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
        vecs[4] = '{len: 7'd64,  exp_err: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
        vecs[5] = '{len: 7'd5,   exp_err: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};

        l_i_csum = '0;
        do_reset();

        // Reset state
        check("rst_hold",  l_o_cpu_hold, 1);
        check("rst_ce",    l_o_cpu_ce, 0);
        check("rst_we",    l_o_we, 0);
        check("rst_waddr", l_o_waddr, 0);
        check("rst_wdata", l_o_wdata, 0);
        check("rst_busy",  l_o_busy, 0);
        check("rst_done",  l_o_done, 0);
        check("rst_err",   l_o_err, 0);
        check("rst_count", l_o_count, 0);
        check("rst_ready", l_o_ready, 0);

        // Start acceptance table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start_load(vecs[i].len);
            check($sformatf("vec%0d_err", i),   l_o_err,   vecs[i].exp_err);
            check($sformatf("vec%0d_busy", i),  l_o_busy,  vecs[i].exp_busy);
            check($sformatf("vec%0d_ready", i), l_o_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_hold", i),  l_o_cpu_hold, 1);
            tick();
            check($sformatf("vec%0d_err_pulse", i), l_o_err, 0);
        end

        // Basic load len=3
        do_reset();
        base = wr_cnt;
        start_load(7'd3);
        check("basic_ready0", l_o_ready, 1);
        for (int i = 0; i < 3; i++) begin
            l_i_valid = 1'b1;
            l_i_data  = w[i];
            tick();
            check($sformatf("basic_we%0d", i),    l_o_we, 1);
            check($sformatf("basic_waddr%0d", i), l_o_waddr, i);
            check($sformatf("basic_wdata%0d", i), l_o_wdata, w[i]);
            check($sformatf("basic_count%0d", i), l_o_count, i + 1);
        end
        check("settle_ready", l_o_ready, 0);
        check("settle_hold",  l_o_cpu_hold, 1);
        check("settle_ce",    l_o_cpu_ce, 0);
        check("settle_busy",  l_o_busy, 1);
        l_i_data = 32'hDEAD_BEEF;
        tick();
        l_i_valid = 1'b0;
        check("run_ce",    l_o_cpu_ce, 1);
        check("run_hold",  l_o_cpu_hold, 0);
        check("run_we",    l_o_we, 0);
        check("run_count", l_o_count, 3);

        // Run completion at PC = 4*len
        l_i_pc = 32'd4;
        tick();
        check("run_pc4", l_o_cpu_ce, 1);
        l_i_pc = 32'd8;
        tick();
        check("run_pc8", l_o_busy, 1);
        l_i_pc = 32'd12;
        tick();
        check("done_done", l_o_done, 1);
        check("done_ce",   l_o_cpu_ce, 0);
        check("done_hold", l_o_cpu_hold, 0);
        check("done_busy", l_o_busy, 0);
        check("basic_nwr", wr_cnt - base, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("basic_mon_addr%0d", i), mon_addr[base + i], i);
            check($sformatf("basic_mon_data%0d", i), mon_data[base + i], w[i]);
        end

        // Reload from DONE with valid toggling
        l_i_pc = '0;
        base = wr_cnt;
        start_load(7'd4);
        check("reload_done", l_o_done, 0);
        check("reload_busy", l_o_busy, 1);
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            l_i_valid = (cyc % 2 == 0);
            l_i_data  = bp[k];
            if (l_i_valid && l_o_ready) k++;
            tick();
        end
        l_i_valid = 1'b0;
        check("bp_budget",     k, 4);
        check("bp_count",      l_o_count, 4);
        check("bp_settle_rdy", l_o_ready, 0);
        check("bp_settle_hld", l_o_cpu_hold, 1);
        tick();
        check("bp_nwr", wr_cnt - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_addr%0d", i), mon_addr[base + i], i);
            check($sformatf("bp_data%0d", i), mon_data[base + i], bp[i]);
        end

        // Reset mid-LOAD
        do_reset();
        base = wr_cnt;
        start_load(7'd5);
        l_i_valid = 1'b1;
        l_i_data  = 32'h0000_0011;
        tick();
        l_i_data  = 32'h0000_0022;
        tick();
        l_rst = 1'b1;
        tick();
        l_rst = 1'b0;
        check("mid_rst_hold",  l_o_cpu_hold, 1);
        check("mid_rst_ce",    l_o_cpu_ce, 0);
        check("mid_rst_we",    l_o_we, 0);
        check("mid_rst_count", l_o_count, 0);
        check("mid_rst_busy",  l_o_busy, 0);
        check("mid_rst_ready", l_o_ready, 0);
        tick();
        tick();
        tick();
        l_i_valid = 1'b0;
        check("mid_rst_nwr", wr_cnt - base, 2);

        // Full-depth load len=64, start during RUN ignored
        do_reset();
        base = wr_cnt;
        start_load(7'd64);
        l_i_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            l_i_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        l_i_valid = 1'b0;
        check("full_waddr", l_o_waddr, 63);
        check("full_wdata", l_o_wdata, 32'hA000_003F);
        check("full_count", l_o_count, 64);
        check("full_ready", l_o_ready, 0);
        tick();
        check("full_run_ce", l_o_cpu_ce, 1);
        start_load(7'd3);
        check("run_start_busy",  l_o_busy, 1);
        check("run_start_ce",    l_o_cpu_ce, 1);
        check("run_start_err",   l_o_err, 0);
        check("run_start_count", l_o_count, 64);
        check("run_start_ready", l_o_ready, 0);
        l_i_pc = 32'd252;
        tick();
        check("full_pc252", l_o_cpu_ce, 1);
        l_i_pc = 32'd256;
        tick();
        check("full_done", l_o_done, 1);
        check("full_nwr", wr_cnt - base, 64);
        check("full_first_addr", mon_addr[base], 0);
        check("full_last_addr", mon_addr[base + 63], 63);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match
        do_reset();
        l_i_csum = 32'd6;
        start_load(7'd3);
        stream3(32'd1, 32'd2, 32'd3);
        tick();
        check("csum_ok_ce",  l_o_cpu_ce, 1);
        check("csum_ok_err", l_o_err, 0);
        check("csum_ok_bsy", l_o_busy, 1);

        // Checksum mismatch
        do_reset();
        l_i_csum = 32'd7;
        start_load(7'd3);
        stream3(32'd1, 32'd2, 32'd3);
        tick();
        check("csum_bad_done", l_o_done, 1);
        check("csum_bad_err",  l_o_err, 1);
        check("csum_bad_ce",   l_o_cpu_ce, 0);
        tick();
        check("csum_bad_err_pulse", l_o_err, 0);
        check("csum_bad_ce2",       l_o_cpu_ce, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
